// File: rtl/dsp_addsub_arbiter.sv
// Round-robin share of one external DSP add/sub among NUM_REQ requesters; DSP_ARB_PERF_EN adds perf counters.
// Latency: grant to rsp_valid is DSP_LAT+1 cycles, one operation in flight at a time.
// Backpressure: rsp_* held while rsp_ready=0; req_ready stays 0 until the response is taken.
module dsp_addsub_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DSP_LAT = 0,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ-1:0]     req_sub,
   input  logic [NUM_REQ*32-1:0]  req_a,
   input  logic [NUM_REQ*32-1:0]  req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [31:0]            rsp_data,
   output logic                   rsp_carry,
   output logic [31:0]            dsp_a,
   output logic [31:0]            dsp_b,
   output logic                   dsp_sub,
   input  logic [31:0]            dsp_result,
   input  logic                   dsp_carry
`ifdef DSP_ARB_PERF_EN
   ,
   output logic [31:0]            perf_ops,
   output logic [31:0]            perf_stall
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state_q;
   logic [ID_W-1:0]     ptr_q;
   logic [1:0]          cnt_q;
   logic [31:0]         dsp_a_q, dsp_b_q, rsp_data_q;
   logic                dsp_sub_q, rsp_valid_q, rsp_carry_q;
   logic [ID_W-1:0]     rsp_id_q;

   logic [2*NUM_REQ-1:0] vld_dbl;
   logic [NUM_REQ-1:0]   vld_rot, gnt_d;
   logic [ID_W:0]        off_d, sum_d;
   logic [ID_W-1:0]      gnt_idx_d;
   logic                 found_d, grant_fire;
   logic [31:0]          sel_a, sel_b;
   logic                 sel_sub;

   // Rotate the valids so bit 0 is the requester right after the last winner.
   assign vld_dbl = {req_valid, req_valid};
   assign vld_rot = NUM_REQ'(vld_dbl >> ({1'b0, ptr_q} + (ID_W+1)'(1)));

   always_comb begin
      found_d = 1'b0;
      off_d   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found_d && vld_rot[k]) begin
            found_d = 1'b1;
            off_d   = (ID_W+1)'(k);
         end
      end
      sum_d = {1'b0, ptr_q} + off_d + (ID_W+1)'(1);
      if (sum_d >= (ID_W+1)'(NUM_REQ)) begin
         sum_d = sum_d - (ID_W+1)'(NUM_REQ);
      end
      gnt_idx_d = sum_d[ID_W-1:0];
      gnt_d     = found_d ? (NUM_REQ'(1) << gnt_idx_d) : '0;
   end

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_sub = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_d[i]) begin
            sel_a   = req_a[i*32 +: 32];
            sel_b   = req_b[i*32 +: 32];
            sel_sub = req_sub[i];
         end
      end
   end

   assign req_ready  = (state_q == IDLE && rst_n) ? gnt_d : '0;
   assign grant_fire = |(req_valid & req_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= ID_W'(NUM_REQ-1);
         cnt_q       <= '0;
         dsp_a_q     <= '0;
         dsp_b_q     <= '0;
         dsp_sub_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_carry_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_fire) begin
                  dsp_a_q   <= sel_a;
                  dsp_b_q   <= sel_b;
                  dsp_sub_q <= sel_sub;
                  rsp_id_q  <= gnt_idx_d;
                  ptr_q     <= gnt_idx_d;
                  cnt_q     <= '0;
                  state_q   <= EXEC;
               end
            end
            EXEC: begin
               if (cnt_q == 2'(DSP_LAT)) begin
                  rsp_data_q  <= dsp_result;
                  rsp_carry_q <= dsp_carry;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dsp_a     = dsp_a_q;
   assign dsp_b     = dsp_b_q;
   assign dsp_sub   = dsp_sub_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_carry = rsp_carry_q;

`ifdef DSP_ARB_PERF_EN
   logic [31:0] perf_ops_q, perf_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_ops_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (rsp_valid_q && rsp_ready && perf_ops_q != 32'hFFFF_FFFF) begin
            perf_ops_q <= perf_ops_q + 32'd1;
         end
         if ((|req_valid) && req_ready == '0 && perf_stall_q != 32'hFFFF_FFFF) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_ops   = perf_ops_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Bench for dsp_addsub_arbiter with a DSP_LAT=2 behavioural DSP; scoreboard of expected responses.
// Expected results are queued at each grant and popped at each response handshake.
// Arbitration order is predicted by an independent round-robin model every cycle.
module tb_dsp_addsub_arbiter;
   localparam int N   = 4;
   localparam int LAT = 2;
   localparam int IW  = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_sub = '0;
   logic [N*32-1:0] req_a = '0;
   logic [N*32-1:0] req_b = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic [IW-1:0]   rsp_id;
   logic [31:0]     rsp_data;
   logic            rsp_carry;
   logic [31:0]     dsp_a, dsp_b, dsp_result;
   logic            dsp_sub, dsp_carry;
`ifdef DSP_ARB_PERF_EN
   logic [31:0]     perf_ops, perf_stall;
`endif

   always #5 clk = ~clk;

   dsp_addsub_arbiter #(.NUM_REQ(N), .DSP_LAT(LAT), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_sub(dsp_sub),
      .dsp_result(dsp_result), .dsp_carry(dsp_carry)
`ifdef DSP_ARB_PERF_EN
      , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
   );

   // Behavioural DSP: two's-complement add/sub followed by LAT pipeline stages.
   logic [32:0] dsp_comb;
   logic [32:0] dsp_pipe [1:3];
   assign dsp_comb = dsp_sub ? ({1'b0, dsp_a} + {1'b0, ~dsp_b} + 33'd1)
                             : ({1'b0, dsp_a} + {1'b0, dsp_b});
   always @(posedge clk) begin
      dsp_pipe[1] <= dsp_comb;
      dsp_pipe[2] <= dsp_pipe[1];
      dsp_pipe[3] <= dsp_pipe[2];
   end
   assign {dsp_carry, dsp_result} = (LAT == 0) ? dsp_comb : dsp_pipe[(LAT == 0) ? 1 : LAT];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [63:0] w;
      if (s) return {(a >= b), 32'(a - b)};
      w = {32'b0, a} + {32'b0, b};
      return {w[32], w[31:0]};
   endfunction

   function automatic logic [N-1:0] rr(input logic [N-1:0] v, input int p);
      logic [N-1:0] one;
      one = 1;
      for (int k = 1; k <= N; k++) begin
         if (v[(p + k) % N]) return one << ((p + k) % N);
      end
      return '0;
   endfunction

   typedef struct packed {
      logic [IW-1:0] id;
      logic          carry;
      logic [31:0]   data;
   } exp_t;

   exp_t         sb [$];
   int           gq [$];
   int           mptr = N-1;
   bit           busy = 1'b0;
   int           cyc_cnt = 0;
   int           grant_cyc = 0;
   int           n_rsp = 0;
   logic [N-1:0] acc = '0;
   logic         prev_vld = 1'b0, prev_rdy = 1'b0, prev_carry = 1'b0;
   logic [31:0]  prev_data = '0;
   logic [IW-1:0] prev_id = '0;

   always @(posedge clk) cyc_cnt++;

   always @(negedge clk) begin
      logic [N-1:0] er;
      logic [32:0]  r;
      exp_t         e;
      int           gi;
      acc = '0;
      if (!rst_n) begin
         mptr = N-1;
         busy = 1'b0;
         sb.delete();
         prev_vld = 1'b0;
      end else begin
         er = busy ? '0 : rr(req_valid, mptr);
         if (busy || req_valid != '0) check("req_ready", req_ready, er);
         if (er != '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (er[i]) gi = i;
            r = ref_op(req_a[gi*32 +: 32], req_b[gi*32 +: 32], req_sub[gi]);
            sb.push_back({IW'(gi), r[32], r[31:0]});
            gq.push_back(gi);
            mptr = gi;
            busy = 1'b1;
            grant_cyc = cyc_cnt;
            acc = er;
         end
         if (prev_vld && !prev_rdy) begin
            check("hold_vld", rsp_valid, 1);
            check("hold_data", rsp_data, prev_data);
            check("hold_id", rsp_id, prev_id);
            check("hold_carry", rsp_carry, prev_carry);
         end
         if (rsp_valid) begin
            if (!prev_vld) check("latency", cyc_cnt - grant_cyc, LAT + 2);
            if (rsp_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_rsp", rsp_valid, 0);
               end else begin
                  e = sb.pop_front();
                  check("rsp_id", rsp_id, e.id);
                  check("rsp_data", rsp_data, e.data);
                  check("rsp_carry", rsp_carry, e.carry);
               end
               busy = 1'b0;
               n_rsp++;
            end
         end
         prev_vld   = rsp_valid;
         prev_rdy   = rsp_ready;
         prev_data  = rsp_data;
         prev_id    = rsp_id;
         prev_carry = rsp_carry;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_sub[i]        = s;
      req_valid[i]      = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      do begin
         cyc();
         t++;
      end while ((busy || req_valid != '0 || sb.size() != 0) && t < budget);
      if (t >= budget) check("timeout_idle", {busy, |req_valid}, 0);
   endtask

   initial begin
      int exp_o [5] = '{0, 1, 2, 3, 0};
      int target, t;

      // Reset values, with requests pending to prove req_ready is held low.
      req_valid = '1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_carry", rsp_carry, 0);
      check("rst_dsp_a", dsp_a, 0);
      check("rst_dsp_b", dsp_b, 0);
      check("rst_dsp_sub", dsp_sub, 0);
      req_valid = '0;
      rst_n = 1'b1;
      cyc();

      set_req(0, 32'd5, 32'd7, 1'b0);
      wait_idle(50);
      set_req(1, 32'd3, 32'd5, 1'b1);
      wait_idle(50);
      set_req(2, 32'd5, 32'd3, 1'b1);
      wait_idle(50);
      set_req(3, 32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_idle(50);

      // Reset while the operation is in EXEC: nothing may come out afterwards.
      set_req(0, 32'd10, 32'd20, 1'b0);
      cyc();
      check("midexec_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_dsp_a", dsp_a, 0);
      check("midrst_rsp_id", rsp_id, 0);
      check("midrst_req_ready", req_ready, 0);
      req_valid = '0;
      cyc();
      rst_n = 1'b1;
      repeat (6) begin
         cyc();
         check("no_rsp_after_rst", rsp_valid, 0);
      end

      // All requesters valid continuously from a fresh pointer.
      gq.delete();
      for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      t = 0;
      while (gq.size() < 5 && t < 200) begin
         cyc();
         t++;
         for (int i = 0; i < N; i++)
            if (!req_valid[i]) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      req_valid = '0;
      if (gq.size() < 5) check("rr_timeout", gq.size(), 5);
      else for (int k = 0; k < 5; k++) check("rr_order", gq[k], exp_o[k]);
      wait_idle(50);

      // Response backpressure with another requester waiting.
      rsp_ready = 1'b0;
      set_req(1, 32'd100, 32'd1, 1'b1);
      t = 0;
      while (!rsp_valid && t < 20) begin
         cyc();
         t++;
      end
      check("bp_rsp_seen", rsp_valid, 1);
      set_req(2, 32'd7, 32'd8, 1'b0);
      repeat (5) begin
         cyc();
         check("bp_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      wait_idle(50);
      check("bp_next_grant", gq[gq.size()-1], 2);

      // Random traffic against the scoreboard.
      target = n_rsp + 3000;
      t = 0;
      while (n_rsp < target && t < 40000) begin
         cyc();
         t++;
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      check("random_done", n_rsp >= target, 1);
      wait_idle(50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
